pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field ID/EX-style stage registers.
- Replaces the global stall/bubble pair with a per-stage valid/ready handshake and a 2-entry skid buffer, so backpressure is registered and never combinationally chained across stages.
- Fields are packed into two buses: CTRL (zeroed on bubble/flush) and DATA (zeroed or held, per parameter).
- Instantiated between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 32, width of packed data payload (PC, operands, immediates, register addresses).
- CTRL_W, 8, width of packed control payload (ALUOp, MemRead, RegWrite, ...); forced to 0 whenever the stage holds a bubble.
- CLEAR_DATA, 1, 1 = data zeroed on flush/bubble; 0 = data held (saves enables/power).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- flush  in  1  discard all held entries; acts as a bubble insert
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage can accept; registered, equals ~skid_valid
- in_data  in  DATA_W  upstream data fields
- in_ctrl  in  CTRL_W  upstream control fields
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  main entry data
- out_ctrl  out  CTRL_W  main entry control; 0 when out_valid=0
- occupancy  out  2  entries held, 0..2

Behaviour:
- State: main entry (drives out_*) and skid entry, each with a valid bit. All outputs registered; no combinational in→out path.
- Reset (rst=1 at edge):
  - main_valid=0, skid_valid=0; all data/ctrl registers 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
  - rst has priority over every other input.
- Accept: acc = in_valid & in_ready. Drain: drn = out_valid & out_ready.
- Next-state, no flush:
  - Main empty, acc: load main. Latency 1 cycle.
  - Main full, drn, !acc: if skid valid, move skid→main and clear skid; else main_valid←0.
  - Main full, drn, acc: if skid empty, input→main; if skid full, skid→main and input→skid. The second case cannot occur because in_ready=0; guard it anyway.
  - Main full, !drn, acc: input→skid; in_ready←0 next cycle.
  - Main full, !drn, !acc: hold.
- Order is strictly FIFO. Sustained throughput is 1 entry/cycle when out_ready=1.
- Bubble rule: any register whose valid bit is 0 after an edge has ctrl=0. It also has data=0 when CLEAR_DATA=1; when CLEAR_DATA=0 its data holds its previous value.
- Flush (flush=1, rst=0) at an edge:
  - Both valid bits←0; ctrl←0; data per CLEAR_DATA.
  - A same-cycle acc is dropped; upstream is flushed by the same hazard unit.
  - A same-cycle drn still completes downstream; this stage just empties.
  - in_ready=1 next cycle.
- occupancy = main_valid + skid_valid. Registered, updated with the entries.
- Invariant: skid_valid ⇒ main_valid. An assertion must flag a violation.
- in_valid with in_ready=0: no state change; upstream must hold its data stable.

Decomposition:
- Shared package pipe_pkg: per-stage CTRL_W/DATA_W constants and field-offset localparams for packing (e.g. EX_CTRL_ALUOP_LSB, WB_CTRL_REGWRITE_BIT), plus an occupancy encoding constant.
- One natural sub-module: pipe_entry. It is a single valid+ctrl+data register with load/clear enables and the CLEAR_DATA rule. It is instantiated twice (main, skid).
- pipe_stage_skid contains only the handshake/steering logic.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_ctrl=8'hFF → out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0; release → first accept lands after 1 cycle.
- Streaming: out_ready=1, push data 1..10 back-to-back → out_data 1..10 in order, one per cycle, 1-cycle latency, occupancy never >1.
- Backpressure: push 5,6,7 with out_ready=0 → in_ready drops after 2 accepts, occupancy=2, 7 not accepted; raise out_ready → outputs 5,6,7 in order and in_ready returns to 1 one cycle after skid drains.
- Flush when full: occupancy=2 holding 8'h3C ctrl, pulse flush with in_valid=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0, incoming entry absent; with CLEAR_DATA=0 out_data retains 32'hDEAD_BEEF, with CLEAR_DATA=1 it is 0.
- Simultaneous: rst=1 and flush=1 with full stage → reset values; flush=1 with acc and drn in same cycle → downstream sees old main once, stage empty next cycle.
- Randomised in_valid/out_ready (50%) for 10k cycles against a scoreboard FIFO → no loss, no duplication, order preserved, skid⇒main assertion never fires.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: per-stage payload widths, control-field offsets
// and the occupancy encoding used by every skid stage.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;

  localparam int IF_ID_DATA_W  = 64;
  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_DATA_W  = 32;
  localparam int ID_EX_CTRL_W  = 8;
  localparam int EX_MEM_DATA_W = 32;
  localparam int EX_MEM_CTRL_W = 4;
  localparam int MEM_WB_DATA_W = 32;
  localparam int MEM_WB_CTRL_W = 2;

  // Control-bus field layout inside the ID/EX control payload
  localparam int EX_CTRL_ALUOP_LSB    = 0;
  localparam int EX_CTRL_ALUOP_W      = 3;
  localparam int EX_CTRL_ALUSRC_BIT   = 3;
  localparam int MEM_CTRL_READ_BIT    = 4;
  localparam int MEM_CTRL_WRITE_BIT   = 5;
  localparam int WB_CTRL_REGWRITE_BIT = 6;
  localparam int WB_CTRL_MEMTOREG_BIT = 7;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_MAX   = 2'd2;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry register: valid bit plus control and data payload.
// Control is zeroed whenever the entry goes invalid; data optionally held.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CTRL_W     = DEF_CTRL_W,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Load wins over clear; a cleared entry becomes a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (CLEAR_DATA) begin
        r_data <= '0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_skid_chk.sv
// Structural invariants of the skid stage, checked every clock outside reset.
module pipe_stage_skid_chk
  import pipe_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       main_valid,
  input logic       skid_valid,
  input logic       in_ready,
  input logic [1:0] occupancy
);

  a_skid_implies_main: assert property (@(posedge clk) disable iff (rst)
    skid_valid |-> main_valid)
    else $error("skid entry valid while main entry empty");

  a_ready_tracks_skid: assert property (@(posedge clk) disable iff (rst)
    in_ready == ~skid_valid)
    else $error("in_ready disagrees with skid entry state");

  a_occ_range: assert property (@(posedge clk) disable iff (rst)
    occupancy <= OCC_MAX)
    else $error("occupancy out of range");

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer;
// in_ready is registered so backpressure never chains combinationally.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int CTRL_W     = DEF_CTRL_W,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              w_main_valid, w_skid_valid;
  logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_ctrl_in;
  logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_data_in;
  logic              w_acc, w_drn;
  logic              w_main_load, w_main_clear, w_main_from_skid;
  logic              w_skid_load, w_skid_clear;
  logic              w_main_valid_nxt, w_skid_valid_nxt;
  logic              r_in_ready;
  logic [1:0]        r_occupancy;

  assign w_acc = in_valid & r_in_ready;
  assign w_drn = w_main_valid & out_ready;

  // Steering: decide which entry loads or clears this cycle
  always_comb begin
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else if (!w_main_valid) begin
      w_main_load = w_acc;
    end else if (w_drn) begin
      if (w_skid_valid) begin
        w_main_load      = 1'b1;
        w_main_from_skid = 1'b1;
        w_skid_load      = w_acc;
        w_skid_clear     = ~w_acc;
      end else begin
        w_main_load  = w_acc;
        w_main_clear = ~w_acc;
      end
    end else begin
      w_skid_load = w_acc & ~w_skid_valid;
    end
    w_main_valid_nxt = w_main_load | (w_main_valid & ~w_main_clear);
    w_skid_valid_nxt = w_skid_load | (w_skid_valid & ~w_skid_clear);
  end

  assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_in = w_main_from_skid ? w_skid_data : in_data;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
    .clk(clk), .rst(rst), .i_load(w_main_load), .i_clear(w_main_clear),
    .i_ctrl(w_main_ctrl_in), .i_data(w_main_data_in),
    .o_valid(w_main_valid), .o_ctrl(w_main_ctrl), .o_data(w_main_data)
  );

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
    .clk(clk), .rst(rst), .i_load(w_skid_load), .i_clear(w_skid_clear),
    .i_ctrl(in_ctrl), .i_data(in_data),
    .o_valid(w_skid_valid), .o_ctrl(w_skid_ctrl), .o_data(w_skid_data)
  );

  // Handshake status registered from the next-state entry valids
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_occupancy <= OCC_EMPTY;
    end else begin
      r_in_ready  <= ~w_skid_valid_nxt;
      r_occupancy <= occ_count(w_main_valid_nxt, w_skid_valid_nxt);
    end
  end

  assign in_ready  = r_in_ready;
  assign occupancy = r_occupancy;
  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_ctrl;
  assign out_data  = w_main_data;

  pipe_stage_skid_chk u_chk (
    .clk(clk), .rst(rst), .main_valid(w_main_valid), .skid_valid(w_skid_valid),
    .in_ready(r_in_ready), .occupancy(r_occupancy)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: two instances (data cleared / data held)
// share stimulus and are compared each cycle against a FIFO reference model.
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 8;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  logic          h_in_ready, h_out_valid;
  logic [DW-1:0] h_out_data;
  logic [CW-1:0] h_out_ctrl;
  logic [1:0]    h_occupancy;

  ent_t          q[$];
  logic [DW-1:0] hold_data = '0;
  bit            started = 1'b0;
  int            vec_cnt = 0;
  int            err_cnt = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0)) dut_hold (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(h_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(h_out_valid), .out_ready(out_ready),
    .out_data(h_out_data), .out_ctrl(h_out_ctrl), .occupancy(h_occupancy)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: check state left by the last edge, then predict the next edge
  always @(negedge clk) begin
    int n;
    if (started) begin
      n = q.size();
      check_val("occupancy", 64'(occupancy), 64'(n));
      check_val("in_ready", 64'(in_ready), (n < 2) ? 64'd1 : 64'd0);
      check_val("out_valid", 64'(out_valid), (n > 0) ? 64'd1 : 64'd0);
      check_val("h_occupancy", 64'(h_occupancy), 64'(n));
      check_val("h_in_ready", 64'(h_in_ready), (n < 2) ? 64'd1 : 64'd0);
      check_val("h_out_valid", 64'(h_out_valid), (n > 0) ? 64'd1 : 64'd0);
      if (n > 0) begin
        hold_data = q[0].d;
        check_val("out_data", 64'(out_data), 64'(q[0].d));
        check_val("out_ctrl", 64'(out_ctrl), 64'(q[0].c));
        check_val("h_out_ctrl", 64'(h_out_ctrl), 64'(q[0].c));
      end else begin
        check_val("bubble_data", 64'(out_data), 64'd0);
        check_val("bubble_ctrl", 64'(out_ctrl), 64'd0);
        check_val("h_bubble_ctrl", 64'(h_out_ctrl), 64'd0);
      end
      check_val("h_out_data", 64'(h_out_data), 64'(hold_data));

      if (rst) begin
        q.delete();
        hold_data = '0;
      end else begin
        if (n > 0 && out_ready) begin
          void'(q.pop_front());
        end
        if (flush) begin
          q.delete();
        end else if (in_valid && n < 2) begin
          q.push_back('{c: in_ctrl, d: in_data});
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'hFF;
    in_data   = 32'h1234_5678;
    out_ready = 1'b0;

    // Two reset cycles with a live upstream offer
    @(posedge clk);
    #1;
    started = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 32'h1234_5678, 8'hFF, 1'b0, 1'b0);
    check_val("first_accept_valid", 64'(out_valid), 64'd1);
    repeat (2) drive(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);

    // Back-to-back streaming
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'(i), 8'(i), 1'b1, 1'b0);
    end
    repeat (2) drive(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);

    // Backpressure: 5 and 6 fill the stage, 7 must wait
    drive(1'b1, 32'd5, 8'h05, 1'b0, 1'b0);
    drive(1'b1, 32'd6, 8'h06, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 32'd7, 8'h07, 1'b0, 1'b0);
    check_val("bp_in_ready", 64'(in_ready), 64'd0);
    check_val("bp_occupancy", 64'(occupancy), 64'd2);
    drive(1'b1, 32'd7, 8'h07, 1'b1, 1'b0);
    check_val("bp_ready_back", 64'(in_ready), 64'd1);
    drive(1'b1, 32'd7, 8'h07, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);

    // Flush with both entries full
    repeat (2) drive(1'b1, 32'hDEAD_BEEF, 8'h3C, 1'b0, 1'b0);
    check_val("full_occupancy", 64'(occupancy), 64'd2);
    drive(1'b1, 32'h0000_0099, 8'h11, 1'b0, 1'b1);
    check_val("flush_occupancy", 64'(occupancy), 64'd0);
    check_val("flush_data_clear", 64'(out_data), 64'd0);
    check_val("flush_data_hold", 64'(h_out_data), 64'hDEAD_BEEF);
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);

    // Reset and flush together on a full stage
    repeat (2) drive(1'b1, 32'hAAAA_5555, 8'h5A, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 32'h0000_0077, 8'h77, 1'b0, 1'b1);
    rst = 1'b0;
    check_val("rstflush_data_hold", 64'(h_out_data), 64'd0);
    drive(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);

    // Flush with accept and drain in the same cycle
    drive(1'b1, 32'h0000_0B0B, 8'h21, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0C0C, 8'h22, 1'b1, 1'b1);
    check_val("flush_drn_valid", 64'(out_valid), 64'd0);
    drive(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);

    // Randomised handshake traffic with occasional flushes
    for (int k = 0; k < 10000; k++) begin
      drive(1'($urandom_range(0, 1)), 32'($urandom), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end
    repeat (3) drive(1'b0, 32'd0, 8'd0, 1'b1, 1'b0);
    check_val("final_empty", 64'(occupancy), 64'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
